// File: rtl/hni_excl_fail_rsp_q_pkg.sv
// Shared types and defaults for the HN-I exclusive-store failure response queue.
// Build option HNI_EXCL_Q_BYPASS_EN is consumed by hni_excl_fail_rsp_q.
package hni_excl_fail_rsp_q_pkg;

  localparam int HNI_EXCL_FAIL_Q_DEPTH = 4;
  localparam int HNI_EXCL_DISCARD_DBID = 0;

  localparam int CHIE_REQ_FLIT_SRCID_WIDTH  = 11;
  localparam int CHIE_REQ_FLIT_TXNID_WIDTH  = 12;
  localparam int CHIE_REQ_FLIT_OPCODE_WIDTH = 7;
  localparam int CHIE_RSP_FLIT_OPCODE_WIDTH = 5;
  localparam int CHIE_RSP_FLIT_DBID_WIDTH   = 12;

  localparam logic [CHIE_RSP_FLIT_OPCODE_WIDTH-1:0] CHIE_COMPDBIDRESP = 5'h05;

  // OK on an exclusive store means the exclusive failed; EXOKAY means it passed.
  typedef enum logic [1:0] {
    RESPERR_OK     = 2'b00,
    RESPERR_EXOKAY = 2'b01,
    RESPERR_DERR   = 2'b10,
    RESPERR_NDERR  = 2'b11
  } resperr_e;

  typedef struct packed {
    logic [3:0]                            qos;
    logic [CHIE_REQ_FLIT_SRCID_WIDTH-1:0]  tgtid;
    logic [CHIE_REQ_FLIT_SRCID_WIDTH-1:0]  srcid;
    logic [CHIE_REQ_FLIT_TXNID_WIDTH-1:0]  txnid;
    logic [CHIE_REQ_FLIT_OPCODE_WIDTH-1:0] opcode;
    logic                                  excl;
  } req_flit_t;

  typedef struct packed {
    logic [CHIE_REQ_FLIT_SRCID_WIDTH-1:0] srcid;
    logic [CHIE_REQ_FLIT_TXNID_WIDTH-1:0] txnid;
  } excl_ent_t;

endpackage

// File: rtl/hni_excl_fail_rsp_q_if.sv
// Response handshake from the exclusive-fail queue to hni_txrsp.
// master = queue (drives the head), slave = hni_txrsp (drives ready).
interface hni_excl_fail_rsp_q_if;
  import hni_excl_fail_rsp_q_pkg::*;

  logic                                  txrsp_excl_valid;
  logic                                  txrsp_excl_ready;
  logic [CHIE_REQ_FLIT_SRCID_WIDTH-1:0]  txrsp_excl_tgtid;
  logic [CHIE_REQ_FLIT_TXNID_WIDTH-1:0]  txrsp_excl_txnid;
  logic [CHIE_RSP_FLIT_OPCODE_WIDTH-1:0] txrsp_excl_opcode;
  logic [1:0]                            txrsp_excl_resperr;
  logic [CHIE_RSP_FLIT_DBID_WIDTH-1:0]   txrsp_excl_dbid;

  modport master (
    output txrsp_excl_valid, txrsp_excl_tgtid, txrsp_excl_txnid,
           txrsp_excl_opcode, txrsp_excl_resperr, txrsp_excl_dbid,
    input  txrsp_excl_ready
  );

  modport slave (
    input  txrsp_excl_valid, txrsp_excl_tgtid, txrsp_excl_txnid,
           txrsp_excl_opcode, txrsp_excl_resperr, txrsp_excl_dbid,
    output txrsp_excl_ready
  );

endinterface

// File: rtl/hni_excl_fifo_ctl.sv
// Pointer/count control for the exclusive-fail queue: pointers, occupancy,
// registered almost-full and sticky overflow. Data storage lives in the parent.
module hni_excl_fifo_ctl #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  output logic             push_ok,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             afull,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             afull_q, afull_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    // A full queue still takes a push when the head leaves in the same cycle.
    push_ok  = push && ((count_q < DEPTH_C) || pop);
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    afull_d  = count_d >= (DEPTH_C - CNT_W'(1));
    ovf_d    = ovf_q || (push && !push_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;
  assign afull  = afull_q;
  assign ovf    = ovf_q;

endmodule

// File: rtl/hni_excl_fail_rsp_q.sv
// Queues failed exclusive stores and presents them to hni_txrsp as CompDBIDResp/OK.
// HNI_EXCL_Q_BYPASS_EN: empty-queue fail is presented in its verdict cycle.
module hni_excl_fail_rsp_q
  import hni_excl_fail_rsp_q_pkg::*;
#(
  parameter int DEPTH        = HNI_EXCL_FAIL_Q_DEPTH,
  parameter int DISCARD_DBID = HNI_EXCL_DISCARD_DBID
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxreq_alloc_en_s0,
  input  req_flit_t             rxreq_alloc_flit_s0,
  input  logic                  excl_pass_s1,
  input  logic                  excl_fail_s1,
  hni_excl_fail_rsp_q_if.master txrsp,
  output logic                  excl_q_afull,
  output logic                  excl_q_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  excl_ent_t        hold_q, hold_d;
  excl_ent_t        mem_q [DEPTH];
  excl_ent_t        mem_d [DEPTH];
  excl_ent_t        head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             q_empty, byp, fifo_push, fifo_pop, push_ok;

  // Pass verdicts are answered by hni_mshr; only the flit identity is kept here.
  logic unused_in;
  assign unused_in = ^{excl_pass_s1, rxreq_alloc_flit_s0.qos, rxreq_alloc_flit_s0.tgtid,
                       rxreq_alloc_flit_s0.opcode, rxreq_alloc_flit_s0.excl};

  assign q_empty = (count == '0);

`ifdef HNI_EXCL_Q_BYPASS_EN
  assign byp = q_empty && excl_fail_s1;
`else
  assign byp = 1'b0;
`endif

  assign fifo_push = excl_fail_s1 && !(byp && txrsp.txrsp_excl_ready);
  assign fifo_pop  = !q_empty && txrsp.txrsp_excl_ready;

  hni_excl_fifo_ctl #(.DEPTH(DEPTH)) u_ctl (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .push_ok (push_ok),
    .wr_ptr  (wr_ptr),
    .rd_ptr  (rd_ptr),
    .count   (count),
    .afull   (excl_q_afull),
    .ovf     (excl_q_ovf)
  );

  always_comb begin
    hold_d = hold_q;
    if (rxreq_alloc_en_s0) begin
      hold_d.srcid = rxreq_alloc_flit_s0.srcid;
      hold_d.txnid = rxreq_alloc_flit_s0.txnid;
    end
    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr] = hold_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      hold_q <= hold_d;
      mem_q  <= mem_d;
    end
  end

  assign head = byp ? hold_q : mem_q[rd_ptr];

  assign txrsp.txrsp_excl_valid   = !q_empty || byp;
  assign txrsp.txrsp_excl_tgtid   = head.srcid;
  assign txrsp.txrsp_excl_txnid   = head.txnid;
  assign txrsp.txrsp_excl_opcode  = CHIE_COMPDBIDRESP;
  assign txrsp.txrsp_excl_resperr = RESPERR_OK;
  assign txrsp.txrsp_excl_dbid    = CHIE_RSP_FLIT_DBID_WIDTH'(DISCARD_DBID);

endmodule
